r0_uio_arbiter: RTL and testbench

// - Shares the 8-bit bidirectional uio pad bus of tt_um_r0 between NREQ on-chip requesters.
// - Grants whole bursts round-robin; owns uio_out/uio_oe; inserts bus-turnaround cycles on direction change.
// - Sits between the core's byte-port clients (e.g. core memory port, debug port) and the top-level uio pins.

---
 rtl/r0_uio_arbiter_pkg.sv | 21 ++
 rtl/r0_uio_arbiter_if.sv | 29 ++
 rtl/r0_uio_arbiter_rr_pick.sv | 33 +++
 rtl/r0_uio_arbiter.sv | 137 +++++++++++++
 tb/tb_r0_uio_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r0_uio_arbiter_pkg.sv
// Shared constants and types for the uio pad-bus arbiter.
package r0_uio_arbiter_pkg;

  localparam int BYTE_W = 8;

  // Pad enables are driven as a whole byte: either all pins out or all pins in.
  localparam logic [BYTE_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [BYTE_W-1:0] OE_FLOAT = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r0_uio_arbiter_if.sv
// Requester-side byte-port bundle between the core clients and the arbiter.
interface r0_uio_arbiter_if #(
  parameter int NREQ = 2
);
  import r0_uio_arbiter_pkg::*;

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_last;
  logic [NREQ-1:0][BYTE_W-1:0] req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             gnt;
  logic [BYTE_W-1:0]           rdata;
  logic [NREQ-1:0]             rvalid;

  // Arbiter side.
  modport slave (
    input  req, req_we, req_valid, req_last, req_wdata,
    output req_ready, gnt, rdata, rvalid
  );

  // Client side.
  modport master (
    output req, req_we, req_valid, req_last, req_wdata,
    input  req_ready, gnt, rdata, rvalid
  );

endinterface

// File: rtl/r0_uio_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping around.
module r0_uio_arbiter_rr_pick
  import r0_uio_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx
);

  // Scan offsets 0..NREQ-1 from the pointer; the first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win     = '0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/r0_uio_arbiter.sv
// Burst-granular round-robin arbiter for the shared 8-bit uio pad bus,
// with bus-turnaround bubbles whenever the pad direction flips.
module r0_uio_arbiter
  import r0_uio_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TURN_CYC  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  r0_uio_arbiter_if.slave   bus,
  input  logic [BYTE_W-1:0] uio_in,
  output logic [BYTE_W-1:0] uio_out,
  output logic [BYTE_W-1:0] uio_oe
);

  localparam int         PTR_W     = ptr_width(NREQ);
  localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

  state_t            state_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic [NREQ-1:0]   rvalid_reg;
  logic [PTR_W-1:0]  owner_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic              last_dir_reg;   // 1 = pins driven, 0 = pins sampled
  logic [1:0]        turn_cnt_reg;
  logic [3:0]        beat_cnt_reg;
  logic [BYTE_W-1:0] rdata_reg;
  logic [BYTE_W-1:0] uio_out_reg;
  logic [BYTE_W-1:0] uio_oe_reg;

  logic [NREQ-1:0]   pick_win;
  logic [PTR_W-1:0]  pick_idx;
  logic [NREQ-1:0]   ready;
  logic              accept;
  logic              burst_end;
  logic [PTR_W-1:0]  next_ptr;

  r0_uio_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr_reg),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  // Only the owner's offered beat is accepted, and only while transferring.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign ready[gi] = (state_reg == XFER) && gnt_reg[gi] && bus.req_valid[gi];
    end
  endgenerate

  assign accept    = |ready;
  assign burst_end = accept && (bus.req_last[owner_reg] || (beat_cnt_reg == BEAT_LAST));
  assign next_ptr  = (owner_reg == PTR_W'(NREQ - 1)) ? '0 : owner_reg + PTR_W'(1);

  // Arbitration FSM with registered grant, pad and read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rvalid_reg   <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      last_dir_reg <= 1'b0;
      turn_cnt_reg <= '0;
      beat_cnt_reg <= '0;
      rdata_reg    <= '0;
      uio_out_reg  <= '0;
      uio_oe_reg   <= OE_FLOAT;
    end else begin
      rvalid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (ena && (|bus.req)) begin
            gnt_reg      <= pick_win;
            owner_reg    <= pick_idx;
            last_dir_reg <= bus.req_we[pick_idx];
            beat_cnt_reg <= '0;
            turn_cnt_reg <= '0;
            if (bus.req_we[pick_idx] != last_dir_reg) begin
              // Release the pins before the other side may drive them.
              state_reg  <= TURN;
              uio_oe_reg <= OE_FLOAT;
            end else begin
              state_reg <= XFER;
            end
          end
        end
        TURN: begin
          if (turn_cnt_reg == TURN_LAST) begin
            state_reg <= XFER;
          end else begin
            turn_cnt_reg <= turn_cnt_reg + 2'd1;
          end
        end
        XFER: begin
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            if (last_dir_reg) begin
              uio_out_reg <= bus.req_wdata[owner_reg];
              uio_oe_reg  <= OE_DRIVE;
            end else begin
              rdata_reg  <= uio_in;
              rvalid_reg <= gnt_reg;
            end
            if (burst_end) begin
              // Pads keep their last state; only a turnaround changes them.
              state_reg    <= IDLE;
              gnt_reg      <= '0;
              rr_ptr_reg   <= next_ptr;
              beat_cnt_reg <= '0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.gnt       = gnt_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.rvalid    = rvalid_reg;
  assign uio_out       = uio_out_reg;
  assign uio_oe        = uio_oe_reg;

endmodule

// File: tb/tb_r0_uio_arbiter.sv
// Self-checking bench for r0_uio_arbiter: table of bursts plus hand sequences,
// with a beat scoreboard checking pad writes and read returns.
module tb_r0_uio_arbiter;

  localparam int NREQ      = 2;
  localparam int TURN_CYC  = 1;
  localparam int MAX_BURST = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       ena    = 1'b0;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  r0_uio_arbiter_if #(.NREQ(NREQ)) bus ();

  r0_uio_arbiter #(
    .NREQ      (NREQ),
    .TURN_CYC  (TURN_CYC),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bus     (bus),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_err     = 0;
  bit mon_en    = 1'b0;
  int ptr_model = 0;

  typedef struct {
    bit             we;
    logic [NREQ-1:0] owner;
    logic [7:0]     data;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int         idx;
    bit         we;
    int         nbeats;
    int         last_at;    // beat number carrying last, 0 = never
    int         stall_at;   // beats accepted before a 3-cycle valid gap, -1 = none
    logic [7:0] base;
    int         exp_beats;
    int         exp_wait;   // granted cycles before the first beat is accepted
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: an accepted beat pushes its expectation, the next cycle pops it.
  always @(negedge clk) begin : mon
    exp_t e;
    int   wi;
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.we) begin
          chk("wr_data", uio_out, e.data);
          chk("wr_oe", uio_oe, 8'hFF);
        end else begin
          chk("rd_valid", bus.rvalid, e.owner);
          chk("rd_data", bus.rdata, e.data);
        end
      end else if (bus.rvalid != '0) begin
        chk("rvalid_spurious", bus.rvalid, 0);
      end
      if (bus.req_ready != '0) begin
        chk("ready_onehot", $onehot(bus.req_ready), 1);
        chk("ready_qual", bus.req_ready & ~bus.req_valid, 0);
        wi = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) wi = i;
        e.we    = bus.req_we[wi];
        e.owner = NREQ'(1) << wi;
        e.data  = bus.req_we[wi] ? bus.req_wdata[wi] : uio_in;
        exp_q.push_back(e);
      end
    end
  end

  task automatic do_burst(input int idx, input bit we, input int nbeats, input int last_at,
                          input int stall_at, input logic [7:0] base, input int exp_beats,
                          input int exp_wait, input bit drop_ena, input bit other_req);
    int         off;
    int         waits;
    int         stall_left;
    bit         stalling;
    bit         seen;
    bit         done;
    logic [7:0] last_wr;
    off = 0; waits = 0; stall_left = 3; stalling = 1'b0; seen = 1'b0; done = 1'b0;
    last_wr = uio_out;
    @(posedge clk); #1;
    bus.req_we[idx] = we;
    bus.req[idx]    = 1'b1;
    if (other_req) begin
      bus.req_we[1-idx]    = 1'b1;
      bus.req[1-idx]       = 1'b1;
      bus.req_valid[1-idx] = 1'b0;
    end
    bus.req_valid[idx] = (nbeats > 0);
    bus.req_wdata[idx] = base;
    uio_in             = base;
    bus.req_last[idx]  = (last_at == 1);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (bus.gnt[idx]) begin
        if (!seen) begin
          seen = 1'b1;
          chk("gnt_lat", cyc, 1);
          if (drop_ena) ena = 1'b0;
        end
        if (stalling) begin
          chk("stall_ready", bus.req_ready[idx], 0);
          if (we) chk("stall_hold", uio_out, last_wr);
        end
        if (bus.req_ready[idx]) begin
          if (!we) chk("rd_oe", uio_oe, 8'h00);
          last_wr = base + 8'(off);
          off++;
        end else if (off == 0) begin
          waits++;
          chk("turn_oe", uio_oe, 8'h00);
        end
      end
      @(posedge clk); #1;
      if (seen && !bus.gnt[idx]) begin
        done = 1'b1;
      end else begin
        stalling = (off == stall_at) && (stall_left > 0);
        if (stalling) stall_left--;
        bus.req_valid[idx] = (off < nbeats) && !stalling;
        bus.req_wdata[idx] = base + 8'(off);
        uio_in             = base + 8'(off);
        bus.req_last[idx]  = (last_at == off + 1);
      end
    end
    bus.req[idx]       = 1'b0;
    bus.req_valid[idx] = 1'b0;
    bus.req_last[idx]  = 1'b0;
    chk("burst_done", done, 1);
    chk("beats", off, exp_beats);
    chk("wait_cyc", waits, exp_wait);
    ptr_model = (idx + 1) % NREQ;
    $display("burst: req%0d we=%0d beats=%0d wait=%0d", idx, we, off, waits);
  endtask

  initial begin : stim
    logic [1:0] exp_g;
    int         grants;
    bit         fin;
    bit         seen_oe;

    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_wdata = '0;

    //           idx we nb last stall base   beats wait
    vecs[0] = '{0, 1, 1, 1, -1, 8'hA5, 1, 1};   // first write after reset: turnaround
    vecs[1] = '{1, 0, 1, 1, -1, 8'h3C, 1, 1};   // write -> read: turnaround
    vecs[2] = '{0, 0, 3, 3, -1, 8'h10, 3, 0};   // read -> read: no bubble
    vecs[3] = '{1, 1, 6, 0, -1, 8'h40, 4, 1};   // no last: cut at MAX_BURST
    vecs[4] = '{0, 1, 4, 0,  2, 8'h50, 4, 0};   // 3-cycle stall mid-burst
    vecs[5] = '{1, 1, 2, 2, -1, 8'h70, 2, 0};   // short write, leaves pointer at 0

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_uio_out", uio_out, 0);
    chk("rst_uio_oe", uio_oe, 0);
    #10 rst_n = 1'b1;
    mon_en = 1'b1;

    // ena=0 blocks new grants.
    @(posedge clk); #1;
    bus.req[0] = 1'b1; bus.req_we[0] = 1'b1; bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ena0_gnt", bus.gnt, 0);
    end
    @(posedge clk); #1;
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    ena = 1'b1;

    for (int i = 0; i < 6; i++)
      do_burst(vecs[i].idx, vecs[i].we, vecs[i].nbeats, vecs[i].last_at, vecs[i].stall_at,
               vecs[i].base, vecs[i].exp_beats, vecs[i].exp_wait, 1'b0, 1'b0);

    // MAX_BURST cut with req1 waiting: req1 must be the next owner.
    do_burst(0, 1'b1, 6, 0, -1, 8'h60, 4, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("maxb_gap", bus.gnt, 2'b00);
    @(negedge clk);
    chk("maxb_next", bus.gnt, 2'b10);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b1; bus.req_wdata[1] = 8'h77;
    fin = 1'b0;
    for (int k = 0; k < 10 && !fin; k++) begin
      @(posedge clk); #1;
      if (!bus.gnt[1]) fin = 1'b1;
    end
    bus.req[1] = 1'b0; bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0;
    chk("maxb_fin", fin, 1);
    ptr_model = 0;

    // Both requesting single-beat writes: strict alternation, no turnaround.
    @(posedge clk); #1;
    bus.req_wdata[0] = 8'h11; bus.req_wdata[1] = 8'h22;
    bus.req = 2'b11; bus.req_we = 2'b11; bus.req_valid = 2'b11; bus.req_last = 2'b11;
    exp_g  = (ptr_model == 0) ? 2'b01 : 2'b10;
    grants = 0;
    for (int c = 0; c < 30 && grants < 4; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        chk("alt_gnt", bus.gnt, exp_g);
        chk("alt_noturn", bus.req_ready, bus.gnt);
        exp_g = {exp_g[0], exp_g[1]};
        grants++;
      end
    end
    @(posedge clk); #1;
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    chk("alt_count", grants, 4);
    $display("alternation: %0d grants", grants);
    ptr_model = exp_g[0] ? 0 : 1;

    // ena dropped during a burst: burst completes, no regrant.
    do_burst(0, 1'b1, 3, 3, -1, 8'h30, 3, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.req[0] = 1'b1; bus.req_we[0] = 1'b1; bus.req_valid[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("ena_noregrant", bus.gnt, 0);
    end
    @(posedge clk); #1;
    bus.req = '0;
    ena = 1'b1;

    // Reset in the middle of a write burst.
    @(posedge clk); #1;
    bus.req[0] = 1'b1; bus.req_we[0] = 1'b1; bus.req_valid[0] = 1'b1;
    bus.req_last[0] = 1'b0; bus.req_wdata[0] = 8'hEE;
    seen_oe = 1'b0;
    for (int k = 0; k < 10 && !seen_oe; k++) begin
      @(negedge clk);
      if (uio_oe == 8'hFF) seen_oe = 1'b1;
    end
    chk("rst_pre_oe", seen_oe, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", uio_oe, 8'h00);
    chk("rst_mid_gnt", bus.gnt, 0);
    chk("rst_mid_rvalid", bus.rvalid, 0);
    chk("rst_mid_ready", bus.req_ready, 0);
    chk("rst_mid_out", uio_out, 8'h00);
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_idle_gnt", bus.gnt, 0);
    // Direction history is back to input: a read needs no turnaround.
    do_burst(1, 1'b0, 1, 1, -1, 8'h99, 1, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
